// File: rtl/writeback_stage_pkg.sv
// Shared Y86-64 pipeline constants: status codes, register/icode encodings
// and the W pipeline register layout with its bubble value.
package writeback_stage_pkg;

    localparam int DATA_WID = 64;
    localparam int ADDR_WID = 4;

    typedef enum logic [2:0] {
        STAT_BUB = 3'd0,
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [ADDR_WID-1:0] RNONE     = 4'hF;
    localparam logic [3:0]          ICODE_NOP = 4'h1;

    typedef struct packed {
        logic [2:0]          stat;
        logic [3:0]          icode;
        logic [DATA_WID-1:0] val_e;
        logic [DATA_WID-1:0] val_m;
        logic [ADDR_WID-1:0] dst_e;
        logic [ADDR_WID-1:0] dst_m;
    } w_reg_t;

    localparam w_reg_t W_BUBBLE = '{
        stat:  STAT_BUB,
        icode: ICODE_NOP,
        val_e: '0,
        val_m: '0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    function automatic logic is_fault(input logic [2:0] stat);
        return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
    endfunction

endpackage

// File: rtl/writeback_stage_pipe_reg.sv
// Generic pipeline register: stall holds, bubble loads BUBBLE, else loads d.
// Stall has priority over bubble; synchronous reset loads BUBBLE.
module writeback_stage_pipe_reg #(
    parameter int               WID    = 8,
    parameter logic [WID-1:0]   BUBBLE = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           bubble,
    input  logic [WID-1:0] d,
    output logic [WID-1:0] q
);

    logic [WID-1:0] q_d;
    logic [WID-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (stall) begin
            q_d = q_q;
        end else if (bubble) begin
            q_d = BUBBLE;
        end else begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 W stage: W pipeline register, register-file write gating, sticky
// halt flag and a saturating retired-instruction counter.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int CNT_WID = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                W_stall,
    input  logic                W_bubble,
    input  logic [2:0]          m_stat,
    input  logic [3:0]          m_icode,
    input  logic [DATA_WID-1:0] m_valE,
    input  logic [DATA_WID-1:0] m_valM,
    input  logic [ADDR_WID-1:0] m_dstE,
    input  logic [ADDR_WID-1:0] m_dstM,
    output logic [DATA_WID-1:0] valE,
    output logic [DATA_WID-1:0] valM,
    output logic [ADDR_WID-1:0] destE,
    output logic [ADDR_WID-1:0] destM,
    output logic [2:0]          W_stat,
    output logic [3:0]          W_icode,
    output logic                halted,
    output logic [CNT_WID-1:0]  retired
);

    w_reg_t w_in;
    w_reg_t w_q;

    logic               halted_d, halted_q;
    logic               fresh_d, fresh_q;
    logic [CNT_WID-1:0] retired_d, retired_q;
    logic               wr_ok;
    logic               count_en;

    assign w_in = '{stat: m_stat, icode: m_icode, val_e: m_valE,
                    val_m: m_valM, dst_e: m_dstE, dst_m: m_dstM};

    // A halted machine freezes W exactly like a stall.
    writeback_stage_pipe_reg #(
        .WID    ($bits(w_reg_t)),
        .BUBBLE (W_BUBBLE)
    ) u_w_reg (
        .clk    (CLK),
        .rst    (RST),
        .stall  (halted_q || W_stall),
        .bubble (W_bubble),
        .d      (w_in),
        .q      (w_q)
    );

    always_comb begin
        halted_d  = halted_q || is_fault(w_q.stat);
        fresh_d   = !(halted_q || W_stall || W_bubble);
        count_en  = fresh_q && (w_q.stat == STAT_AOK) && !halted_q;
        retired_d = retired_q;
        if (count_en && (retired_q != {CNT_WID{1'b1}})) begin
            retired_d = retired_q + CNT_WID'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            halted_q  <= 1'b0;
            fresh_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            halted_q  <= halted_d;
            fresh_q   <= fresh_d;
            retired_q <= retired_d;
        end
    end

    // On a same-register conflict only the M write (load result) survives.
    assign wr_ok   = (w_q.stat == STAT_AOK) && !halted_q;
    assign destM   = wr_ok ? w_q.dst_m : RNONE;
    assign destE   = (wr_ok && (w_q.dst_e != w_q.dst_m)) ? w_q.dst_e : RNONE;
    assign valE    = w_q.val_e;
    assign valM    = w_q.val_m;
    assign W_stat  = w_q.stat;
    assign W_icode = w_q.icode;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule
